// File: rtl/aes_dec_pkg.sv
// Shared types and constants for the AES-128 decryption path.
package aes_dec_pkg;

  localparam int unsigned AES_NR128 = 10;
  localparam int unsigned AES_KW    = 128;

  typedef enum logic [1:0] {
    RKS_EMPTY,
    RKS_LOADING,
    RKS_READY,
    RKS_READING
  } rks_state_t;

  typedef logic [0:3] round_idx_t;

endpackage

// File: rtl/rkey_ram.sv
// Round-key storage: one synchronous write port, one synchronous read port with registered output.
module rkey_ram
  import aes_dec_pkg::*;
#(
  parameter int unsigned DEPTH = AES_NR128 + 1,
  parameter int unsigned KW    = AES_KW
) (
  input  logic          clk,
  input  logic          we,
  input  round_idx_t    waddr,
  input  logic [0:KW-1] wdata,
  input  logic          re,
  input  round_idx_t    raddr,
  output logic [0:KW-1] rdata
);

  logic [0:KW-1] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/round_key_store.sv
// Captures the forward key schedule from the expander and plays it back round NR..0
// for the inverse cipher; the schedule is reusable until a new key is loaded.
module round_key_store
  import aes_dec_pkg::*;
#(
  parameter int unsigned NR = AES_NR128,
  parameter int unsigned KW = AES_KW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [0:KW-1] rkey,
  input  logic          rkey_vld,
  input  logic          rkey_last,
  output logic          load_ok,
  output logic          keys_rdy,
  input  logic          rd_start,
  input  logic          rd_adv,
  output logic [0:KW-1] rk,
  output logic          rk_vld,
  output round_idx_t    rk_round,
  output logic          rk_last,
  output logic          seq_err
);

  localparam round_idx_t LAST_IDX = round_idx_t'(NR);

  rks_state_t    state, state_n;
  round_idx_t    wr_idx, wr_idx_n;
  round_idx_t    rd_idx, rd_idx_n;
  logic          rk_vld_q, rk_vld_n;
  logic          seq_err_q, seq_err_n;
  logic          key_ok;
  logic          ram_we, ram_re;
  round_idx_t    ram_raddr;
  logic [0:KW-1] ram_q;

  rkey_ram #(
    .DEPTH(NR + 1),
    .KW   (KW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(wr_idx),
    .wdata(rkey),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(ram_q)
  );

  always_comb begin
    state_n   = state;
    wr_idx_n  = wr_idx;
    rd_idx_n  = rd_idx;
    rk_vld_n  = rk_vld_q;
    seq_err_n = seq_err_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_raddr = rd_idx;
    key_ok    = (rkey_last == (wr_idx == LAST_IDX));

    // A write always takes priority over the read side and cancels any playback.
    if (rkey_vld) begin
      rk_vld_n = 1'b0;
      if (!key_ok) begin
        seq_err_n = 1'b1;
        wr_idx_n  = '0;
        state_n   = RKS_EMPTY;
      end else begin
        ram_we = 1'b1;
        if (state == RKS_READING) seq_err_n = 1'b1;
        if (rkey_last) begin
          wr_idx_n = '0;
          state_n  = RKS_READY;
        end else begin
          wr_idx_n = wr_idx + round_idx_t'(1);
          state_n  = RKS_LOADING;
        end
      end
    end else if (state == RKS_READY || state == RKS_READING) begin
      if (rd_start) begin
        rd_idx_n  = LAST_IDX;
        rk_vld_n  = 1'b1;
        state_n   = RKS_READING;
        ram_re    = 1'b1;
        ram_raddr = LAST_IDX;
      end else if (rd_adv && rk_vld_q) begin
        if (rd_idx != '0) begin
          rd_idx_n  = rd_idx - round_idx_t'(1);
          ram_re    = 1'b1;
          ram_raddr = rd_idx - round_idx_t'(1);
        end else begin
          rk_vld_n = 1'b0;
          state_n  = RKS_READY;
        end
      end
    end

    if (!rst_n) begin
      ram_we = 1'b0;
      ram_re = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RKS_EMPTY;
      wr_idx    <= '0;
      rd_idx    <= '0;
      rk_vld_q  <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      state     <= state_n;
      wr_idx    <= wr_idx_n;
      rd_idx    <= rd_idx_n;
      rk_vld_q  <= rk_vld_n;
      seq_err_q <= seq_err_n;
    end
  end

  // The RAM output register has no reset, so rk is forced to zero whenever it is not valid.
  assign rk       = rk_vld_q ? ram_q : '0;
  assign rk_vld   = rk_vld_q;
  assign rk_round = rd_idx;
  assign rk_last  = rk_vld_q && (rd_idx == '0);
  assign seq_err  = seq_err_q;
  assign load_ok  = (state == RKS_EMPTY) || (state == RKS_READY);
  assign keys_rdy = (state == RKS_READY) || (state == RKS_READING);

endmodule

// File: tb/tb_round_key_store.sv
// Self-checking bench for round_key_store: FIPS-197 schedule playback, protocol errors, random traffic.
module tb_round_key_store;
  import aes_dec_pkg::*;

  localparam int unsigned NR = 10;
  localparam int unsigned KW = 128;

  logic          clk = 1'b0;
  logic          rst_n, rkey_vld, rkey_last, rd_start, rd_adv;
  logic          load_ok, keys_rdy, rk_vld, rk_last, seq_err;
  logic [0:KW-1] rkey, rk;
  round_idx_t    rk_round;

  always #5 clk = ~clk;

  round_key_store #(.NR(NR), .KW(KW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rkey     (rkey),
    .rkey_vld (rkey_vld),
    .rkey_last(rkey_last),
    .load_ok  (load_ok),
    .keys_rdy (keys_rdy),
    .rd_start (rd_start),
    .rd_adv   (rd_adv),
    .rk       (rk),
    .rk_vld   (rk_vld),
    .rk_round (rk_round),
    .rk_last  (rk_last),
    .seq_err  (seq_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference model: what has been stored, whether a full schedule exists,
  // how many keys of a pending load have arrived, and which round is on show.
  logic [127:0] m_mem [0:NR];
  int           m_fill = 0;
  int           m_play = -1;
  bit           m_have = 1'b0;
  bit           m_err  = 1'b0;

  logic [127:0] sched [0:NR];
  logic [127:0] fips  [0:NR];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00)
      for (int y = 1; y < 256; y++)
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic model_update(input bit rst, input bit v, input bit l, input logic [127:0] k,
                              input bit s, input bit a);
    bit final_slot;
    if (!rst) begin
      m_fill = 0; m_have = 1'b0; m_play = -1; m_err = 1'b0;
    end else if (v) begin
      final_slot = (m_fill == NR);
      if (l != final_slot) begin
        m_err = 1'b1; m_fill = 0; m_have = 1'b0;
      end else begin
        m_mem[m_fill] = k;
        if (m_play >= 0) m_err = 1'b1;
        if (l) begin m_fill = 0; m_have = 1'b1; end
        else begin m_fill++; m_have = 1'b0; end
      end
      m_play = -1;
    end else if (m_have) begin
      if (s) m_play = NR;
      else if (a && m_play >= 0) m_play--;
    end
  endtask

  task automatic compare_all();
    check("load_ok",  load_ok,  (m_fill == 0 && m_play < 0));
    check("keys_rdy", keys_rdy, m_have);
    check("seq_err",  seq_err,  m_err);
    check("rk_vld",   rk_vld,   (m_play >= 0));
    check("rk_last",  rk_last,  (m_play == 0));
    if (m_play >= 0) begin
      check("rk",       rk,       m_mem[m_play]);
      check("rk_round", rk_round, m_play);
    end
  endtask

  // One clock: drive inputs, advance model at the edge, sample 1 time unit later.
  task automatic cyc(input bit rst, input bit v, input bit l, input logic [127:0] k,
                     input bit s, input bit a);
    rst_n = rst; rkey_vld = v; rkey_last = l; rkey = k; rd_start = s; rd_adv = a;
    @(posedge clk);
    model_update(rst, v, l, k, s, a);
    #1;
    compare_all();
  endtask

  task automatic load_sched();
    for (int i = 0; i <= NR; i++) cyc(1, 1, (i == NR), sched[i], 0, 0);
  endtask

  task automatic idle_adv(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, '0, 0, 1);
  endtask

  initial begin
    int  sent;
    bit  loading, rst, v, l, s, a;

    rst_n = 1'b0; rkey_vld = 1'b0; rkey_last = 1'b0; rkey = '0; rd_start = 1'b0; rd_adv = 1'b0;
    expand_key(128'h000102030405060708090a0b0c0d0e0f);
    fips = sched;

    cyc(0, 0, 0, '0, 0, 0);
    cyc(0, 0, 0, '0, 0, 0);
    check("rst_rk", rk, '0);
    check("rst_round", rk_round, 0);

    cyc(1, 0, 0, '0, 1, 0);
    check("start_empty_vld", rk_vld, 1'b0);

    for (int i = 0; i <= NR; i++) cyc(1, 1, (i == NR), fips[i], (i == 3), 0);

    cyc(1, 0, 0, '0, 1, 1);
    check("fips_r10", rk, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    for (int r = NR - 1; r >= 0; r--) begin
      cyc(1, 0, 0, '0, 0, 1);
      if (r == 9) check("fips_r9", rk, 128'h549932d1f08557681093ed9cbe2c974e);
    end
    check("fips_r0", rk, 128'h000102030405060708090a0b0c0d0e0f);
    check("fips_last", rk_last, 1'b1);
    cyc(1, 0, 0, '0, 0, 1);
    check("end_vld", rk_vld, 1'b0);

    cyc(1, 0, 0, '0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, '0, 0, 0);
    check("stall_round", rk_round, 10);
    cyc(1, 0, 0, '0, 0, 1);
    check("stall_adv_round", rk_round, 9);
    idle_adv(10);

    cyc(1, 0, 0, '0, 1, 1);
    idle_adv(11);
    check("reuse_seq_err", seq_err, 1'b0);

    cyc(1, 0, 0, '0, 1, 0);
    idle_adv(6);
    check("pre_restart_round", rk_round, 4);
    cyc(1, 0, 0, '0, 1, 1);
    check("restart_round", rk_round, 10);

    idle_adv(4);
    check("pre_rst_round", rk_round, 6);
    cyc(0, 0, 0, '0, 0, 1);
    check("midread_rst_vld", rk_vld, 1'b0);
    check("midread_rst_load_ok", load_ok, 1'b1);

    for (int i = 0; i < 5; i++) cyc(1, 1, (i == 4), {$urandom, $urandom, $urandom, $urandom}, 0, 0);
    check("err_last5", seq_err, 1'b1);
    check("err_last5_load_ok", load_ok, 1'b1);

    for (int i = 0; i <= NR; i++) sched[i] = {$urandom, $urandom, $urandom, $urandom};
    load_sched();
    cyc(1, 0, 0, '0, 1, 0);
    idle_adv(2);
    cyc(1, 1, 0, {$urandom, $urandom, $urandom, $urandom}, 0, 0);
    check("err_read_vld", rk_vld, 1'b0);
    check("err_read_load_ok", load_ok, 1'b0);
    for (int i = 1; i <= NR; i++) cyc(1, 1, (i == NR), {$urandom, $urandom, $urandom, $urandom}, 0, 0);
    cyc(1, 0, 0, '0, 1, 0);
    for (int i = 0; i < 30; i++) cyc(1, 0, 0, '0, 0, ($urandom % 2 == 0));

    sent = 0; loading = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom % 600) != 0;
      v = 1'b0; l = 1'b0;
      if (loading) begin
        v = ($urandom % 4) != 0;
        if (v) begin
          l = (sent == NR) ^ (($urandom % 50) == 0);
          sent++;
          if (l || sent > NR) loading = 1'b0;
        end
      end else if (($urandom % 30) == 0) begin
        loading = 1'b1; sent = 0;
      end
      s = ($urandom % 12) == 0;
      a = ($urandom % 3) != 0;
      cyc(rst, v, l, {$urandom, $urandom, $urandom, $urandom}, s, a);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
